// File: rtl/instr_encoder_pkg.sv
// Shared MIPS encoding definitions: format codes, loader states and
// instruction field bit positions (common with the field decoder).
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_ILL = 2'd3;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int RS_MSB   = 25;
  localparam int RS_LSB   = 21;
  localparam int RT_MSB   = 20;
  localparam int RT_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int SH_MSB   = 10;
  localparam int SH_LSB   = 6;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int TGT_MSB  = 25;
  localparam int TGT_LSB  = 0;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; dout always shows the head entry.
// Storage resets to zero so an empty FIFO presents a zero head after reset.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded MIPS field bundles into instruction words and streams them
// through a FIFO into consecutive instruction-memory addresses.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  func,
  input  logic [15:0] imm16,
  input  logic [27:0] target,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [15:0] word_cnt,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic        done
);

  state_t      state;
  state_t      state_next;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_dout;
  logic [31:0] enc_word;
  logic        accept;
  logic        reject;
  logic        push;
  logic        pop;

  function automatic logic [31:0] encode_word(
    input logic [1:0]  f,
    input logic [5:0]  o,
    input logic [4:0]  s,
    input logic [4:0]  t,
    input logic [4:0]  d,
    input logic [4:0]  sh,
    input logic [5:0]  fn,
    input logic [15:0] im,
    input logic [25:0] tw
  );
    logic [31:0] w;
    w = '0;
    case (f)
      FMT_R: begin
        w[OP_MSB:OP_LSB]     = o;
        w[RS_MSB:RS_LSB]     = s;
        w[RT_MSB:RT_LSB]     = t;
        w[RD_MSB:RD_LSB]     = d;
        w[SH_MSB:SH_LSB]     = sh;
        w[FUNC_MSB:FUNC_LSB] = fn;
      end
      FMT_I: begin
        w[OP_MSB:OP_LSB]   = o;
        w[RS_MSB:RS_LSB]   = s;
        w[RT_MSB:RT_LSB]   = t;
        w[IMM_MSB:IMM_LSB] = im;
      end
      FMT_J: begin
        w[OP_MSB:OP_LSB]   = o;
        w[TGT_MSB:TGT_LSB] = tw;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  // Rejected bundles are still consumed so the producer never stalls on them.
  assign accept   = in_valid && in_ready;
  assign reject   = (fmt == FMT_ILL) || ((fmt == FMT_J) && (target[1:0] != 2'b00));
  assign push     = accept && !reject;
  assign pop      = mem_we && mem_ready;
  assign enc_word = encode_word(fmt, op, rs, rt, rd, shamt, func, imm16, target[27:2]);
  assign mem_we    = !fifo_empty;
  assign mem_wdata = fifo_dout;

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (enc_word),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_LOAD;
      ST_LOAD:  if (flush) state_next = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_LOAD) && !fifo_full;
    done     = (state == ST_DONE);
  end

  // start is only honoured in IDLE, where no write or accept can coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= BASE_ADDR;
      word_cnt <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      err <= accept && reject;
      if ((state == ST_IDLE) && start) begin
        mem_addr <= BASE_ADDR;
        word_cnt <= '0;
        err_cnt  <= '0;
      end else begin
        if (pop) begin
          mem_addr <= mem_addr + 32'd4;
          if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
        end
        if (accept && reject && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
